// File: rtl/writeback_register_file_if.sv
// Bundle between the MEM/WB pipeline register, the ID-stage read ports and the forwarding unit.
// Master drives the write-back inputs and read indices; slave (the register file) returns data.
interface writeback_register_file_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_to_reg_i;
  logic                  reg_write_i;
  logic                  jmp_i;
  logic [4:0]            write_register_i;
  logic [DATA_WIDTH-1:0] pc_plus_4_i;
  logic [DATA_WIDTH-1:0] read_data_mmry_i;
  logic [DATA_WIDTH-1:0] alu_result_i;
  logic [4:0]            read_register_1_i;
  logic [4:0]            read_register_2_i;
  logic [DATA_WIDTH-1:0] read_data_1_o;
  logic [DATA_WIDTH-1:0] read_data_2_o;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [4:0]            wb_register_o;
  logic                  wb_valid_o;

  modport master (
    output mem_to_reg_i, reg_write_i, jmp_i, write_register_i, pc_plus_4_i,
           read_data_mmry_i, alu_result_i, read_register_1_i, read_register_2_i,
    input  read_data_1_o, read_data_2_o, wb_data_o, wb_register_o, wb_valid_o
  );

  modport slave (
    input  mem_to_reg_i, reg_write_i, jmp_i, write_register_i, pc_plus_4_i,
           read_data_mmry_i, alu_result_i, read_register_1_i, read_register_2_i,
    output read_data_1_o, read_data_2_o, wb_data_o, wb_register_o, wb_valid_o
  );
endinterface

// File: rtl/writeback_register_file.sv
// Write-back mux plus 32-entry GPR file with write-first bypass on both read ports.
// Reads are combinational (same-cycle bypass); commits on the clock edge; no backpressure.
module writeback_register_file #(
  parameter int                    DATA_WIDTH           = 32,
  parameter logic [DATA_WIDTH-1:0] STACK_POINTER_RESET  = 32'h7FFF_EFFC,
  parameter logic [DATA_WIDTH-1:0] GLOBAL_POINTER_RESET = 32'h1000_8000,
  parameter int unsigned           LINK_REGISTER        = 31
) (
  input  logic                          clk,
  input  logic                          reset,
  writeback_register_file_if.slave      wb
);

  localparam logic [4:0] LINK_IDX = 5'(LINK_REGISTER);

  logic [DATA_WIDTH-1:0] regs [32];
  logic [DATA_WIDTH-1:0] wb_data;
  logic [4:0]            wb_dest;
  logic                  wb_valid;

  always_comb begin
    wb_data = wb.alu_result_i;
    if (wb.jmp_i) begin
      wb_data = wb.pc_plus_4_i;
    end else if (wb.mem_to_reg_i) begin
      wb_data = wb.read_data_mmry_i;
    end
  end

  assign wb_dest  = wb.jmp_i ? LINK_IDX : wb.write_register_i;
  // Gating with reset also disables the bypass while the array is held at reset values.
  assign wb_valid = wb.reg_write_i & (wb_dest != 5'd0) & ~reset;

  assign wb.wb_data_o     = wb_data;
  assign wb.wb_register_o = wb_dest;
  assign wb.wb_valid_o    = wb_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      regs[28] <= GLOBAL_POINTER_RESET;
      regs[29] <= STACK_POINTER_RESET;
    end else if (wb_valid) begin
      regs[wb_dest] <= wb_data;
    end
  end

  always_comb begin
    wb.read_data_1_o = regs[wb.read_register_1_i];
    if (wb.read_register_1_i == 5'd0) begin
      wb.read_data_1_o = '0;
    end else if (wb_valid && (wb.read_register_1_i == wb_dest)) begin
      wb.read_data_1_o = wb_data;
    end
  end

  always_comb begin
    wb.read_data_2_o = regs[wb.read_register_2_i];
    if (wb.read_register_2_i == 5'd0) begin
      wb.read_data_2_o = '0;
    end else if (wb_valid && (wb.read_register_2_i == wb_dest)) begin
      wb.read_data_2_o = wb_data;
    end
  end

endmodule

// File: tb/tb_writeback_register_file.sv
// Bench for writeback_register_file: directed scenarios then randomized traffic vs. an array model.
module tb_writeback_register_file;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];

  writeback_register_file_if #(.DATA_WIDTH(32)) ifc ();

  writeback_register_file #(
    .DATA_WIDTH(32),
    .STACK_POINTER_RESET(32'h7FFF_EFFC),
    .GLOBAL_POINTER_RESET(32'h1000_8000),
    .LINK_REGISTER(31)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wb(ifc)
  );

  always #5 clk = ~clk;

  // Reference: architectural register contents after reset.
  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[28] = 32'h1000_8000;
    model[29] = 32'h7FFF_EFFC;
  endtask

  function automatic logic [31:0] m_data();
    if (ifc.jmp_i) return ifc.pc_plus_4_i;
    if (ifc.mem_to_reg_i) return ifc.read_data_mmry_i;
    return ifc.alu_result_i;
  endfunction

  function automatic logic [4:0] m_dest();
    return ifc.jmp_i ? 5'd31 : ifc.write_register_i;
  endfunction

  function automatic logic m_valid();
    return ifc.reg_write_i && (m_dest() != 5'd0) && !reset;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (m_valid() && idx == m_dest()) return m_data();
    return model[idx];
  endfunction

  task automatic idle();
    ifc.mem_to_reg_i = 1'b0;
    ifc.reg_write_i = 1'b0;
    ifc.jmp_i = 1'b0;
    ifc.write_register_i = 5'd0;
    ifc.pc_plus_4_i = 32'h0;
    ifc.read_data_mmry_i = 32'h0;
    ifc.alu_result_i = 32'h0;
    ifc.read_register_1_i = 5'd0;
    ifc.read_register_2_i = 5'd0;
  endtask

  // Advance one clock edge, committing in the model, and return to the negedge.
  task automatic edge_commit();
    @(posedge clk);
    if (m_valid()) model[m_dest()] = m_data();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    ifc.reg_write_i = 1'b1;
    ifc.write_register_i = 5'd5;
    ifc.alu_result_i = 32'h5555_5555;
    edge_commit();
    ifc.write_register_i = 5'd29;
    ifc.alu_result_i = 32'h0000_0001;
    edge_commit();
    ifc.write_register_i = 5'd29;
    ifc.alu_result_i = 32'hABCD_0000;
    ifc.read_register_1_i = 5'd29;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (ifc.wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_wb_valid got=%b exp=0", ifc.wb_valid_o);
    end
    checks++;
    if (ifc.read_data_1_o !== 32'h7FFF_EFFC) begin
      errors++; $display("FAIL reset_no_bypass got=%h exp=7fffeffc", ifc.read_data_1_o);
    end
    #1;
    reset = 1'b0;
    ifc.reg_write_i = 1'b0;
    ifc.read_register_2_i = 5'd28;
    #1;
    checks++;
    if (ifc.read_data_1_o !== 32'h7FFF_EFFC) begin
      errors++; $display("FAIL reset_sp got=%h exp=7fffeffc", ifc.read_data_1_o);
    end
    checks++;
    if (ifc.read_data_2_o !== 32'h1000_8000) begin
      errors++; $display("FAIL reset_gp got=%h exp=10008000", ifc.read_data_2_o);
    end
    ifc.read_register_1_i = 5'd5;
    #1;
    checks++;
    if (ifc.read_data_1_o !== 32'h0) begin
      errors++; $display("FAIL reset_r5 got=%h exp=0", ifc.read_data_1_o);
    end
    @(negedge clk);
  endtask

  task automatic test_alu_write();
    idle();
    ifc.reg_write_i = 1'b1;
    ifc.write_register_i = 5'd8;
    ifc.alu_result_i = 32'h0000_1234;
    ifc.read_register_1_i = 5'd8;
    #1;
    checks++;
    if (ifc.read_data_1_o !== 32'h0000_1234) begin
      errors++; $display("FAIL alu_bypass got=%h exp=00001234", ifc.read_data_1_o);
    end
    checks++;
    if (ifc.wb_valid_o !== 1'b1) begin
      errors++; $display("FAIL alu_wb_valid got=%b exp=1", ifc.wb_valid_o);
    end
    edge_commit();
    ifc.reg_write_i = 1'b0;
    ifc.alu_result_i = 32'h0BAD_0BAD;
    #1;
    checks++;
    if (ifc.read_data_1_o !== 32'h0000_1234) begin
      errors++; $display("FAIL alu_stored got=%h exp=00001234", ifc.read_data_1_o);
    end
    @(negedge clk);
  endtask

  task automatic test_load();
    idle();
    ifc.reg_write_i = 1'b1;
    ifc.mem_to_reg_i = 1'b1;
    ifc.read_data_mmry_i = 32'hDEAD_BEEF;
    ifc.alu_result_i = 32'h0000_0001;
    ifc.write_register_i = 5'd9;
    ifc.read_register_1_i = 5'd9;
    ifc.read_register_2_i = 5'd9;
    #1;
    checks++;
    if (ifc.read_data_2_o !== 32'hDEAD_BEEF || ifc.read_data_1_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL load_dual_bypass got=%h/%h exp=deadbeef", ifc.read_data_1_o, ifc.read_data_2_o);
    end
    edge_commit();
    ifc.reg_write_i = 1'b0;
    ifc.read_data_mmry_i = 32'h1111_1111;
    ifc.alu_result_i = 32'h2222_2222;
    edge_commit();
    #1;
    checks++;
    if (ifc.read_data_1_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL load_no_write got=%h exp=deadbeef", ifc.read_data_1_o);
    end
    @(negedge clk);
  endtask

  task automatic test_jal();
    idle();
    ifc.jmp_i = 1'b1;
    ifc.reg_write_i = 1'b1;
    ifc.write_register_i = 5'd3;
    ifc.mem_to_reg_i = 1'b1;
    ifc.read_data_mmry_i = 32'h7777_7777;
    ifc.pc_plus_4_i = 32'h0040_0010;
    #1;
    checks++;
    if (ifc.wb_register_o !== 5'd31) begin
      errors++; $display("FAIL jal_dest got=%0d exp=31", ifc.wb_register_o);
    end
    checks++;
    if (ifc.wb_data_o !== 32'h0040_0010) begin
      errors++; $display("FAIL jal_data got=%h exp=00400010", ifc.wb_data_o);
    end
    edge_commit();
    ifc.reg_write_i = 1'b0;
    ifc.pc_plus_4_i = 32'h0040_0100;
    ifc.read_register_1_i = 5'd31;
    ifc.read_register_2_i = 5'd3;
    edge_commit();
    #1;
    checks++;
    if (ifc.read_data_1_o !== 32'h0040_0010) begin
      errors++; $display("FAIL jal_r31 got=%h exp=00400010", ifc.read_data_1_o);
    end
    checks++;
    if (ifc.read_data_2_o !== 32'h0) begin
      errors++; $display("FAIL jal_r3 got=%h exp=0", ifc.read_data_2_o);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    idle();
    ifc.reg_write_i = 1'b1;
    ifc.write_register_i = 5'd0;
    ifc.alu_result_i = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (ifc.wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL zero_wb_valid got=%b exp=0", ifc.wb_valid_o);
    end
    checks++;
    if (ifc.read_data_1_o !== 32'h0 || ifc.read_data_2_o !== 32'h0) begin
      errors++; $display("FAIL zero_bypass got=%h/%h exp=0", ifc.read_data_1_o, ifc.read_data_2_o);
    end
    edge_commit();
    ifc.reg_write_i = 1'b0;
    #1;
    checks++;
    if (ifc.read_data_1_o !== 32'h0 || ifc.read_data_2_o !== 32'h0) begin
      errors++; $display("FAIL zero_stored got=%h/%h exp=0", ifc.read_data_1_o, ifc.read_data_2_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    idle();
    ifc.reg_write_i = 1'b1;
    ifc.write_register_i = 5'd10;
    ifc.alu_result_i = 32'hA5A5_A5A5;
    ifc.read_register_1_i = 5'd10;
    ifc.read_register_2_i = 5'd8;
    #1;
    checks++;
    if (ifc.read_data_1_o !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL midrst_bypass got=%h exp=a5a5a5a5", ifc.read_data_1_o);
    end
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ifc.reg_write_i = 1'b0;
    #1;
    checks++;
    if (ifc.read_data_1_o !== 32'h0) begin
      errors++; $display("FAIL midrst_r10 got=%h exp=0", ifc.read_data_1_o);
    end
    checks++;
    if (ifc.read_data_2_o !== 32'h0) begin
      errors++; $display("FAIL midrst_r8 got=%h exp=0", ifc.read_data_2_o);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [4:0] hot;
    for (int n = 0; n < 400; n++) begin
      hot = 5'($urandom_range(0, 31));
      ifc.reg_write_i = ($urandom_range(0, 3) != 0);
      ifc.jmp_i = ($urandom_range(0, 7) == 0);
      ifc.mem_to_reg_i = 1'($urandom);
      ifc.write_register_i = ($urandom_range(0, 7) == 0) ? 5'd0 : hot;
      ifc.pc_plus_4_i = $urandom;
      ifc.read_data_mmry_i = $urandom;
      ifc.alu_result_i = $urandom;
      ifc.read_register_1_i = ($urandom_range(0, 2) == 0) ? hot : 5'($urandom_range(0, 31));
      ifc.read_register_2_i = ($urandom_range(0, 2) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      #1;
      checks++;
      if (ifc.wb_valid_o !== m_valid() || ifc.wb_register_o !== m_dest() || ifc.wb_data_o !== m_data()) begin
        errors++;
        $display("FAIL rand_wb n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n, ifc.wb_valid_o,
                 ifc.wb_register_o, ifc.wb_data_o, m_valid(), m_dest(), m_data());
      end
      checks++;
      if (ifc.read_data_1_o !== m_read(ifc.read_register_1_i)) begin
        errors++;
        $display("FAIL rand_rd1 n=%0d idx=%0d got=%h exp=%h", n, ifc.read_register_1_i,
                 ifc.read_data_1_o, m_read(ifc.read_register_1_i));
      end
      checks++;
      if (ifc.read_data_2_o !== m_read(ifc.read_register_2_i)) begin
        errors++;
        $display("FAIL rand_rd2 n=%0d idx=%0d got=%h exp=%h", n, ifc.read_register_2_i,
                 ifc.read_data_2_o, m_read(ifc.read_register_2_i));
      end
      edge_commit();
      reset = 1'b0;
    end
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu_write();
    test_load();
    test_jal();
    test_zero();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
